// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: widths, result-source
// encodings, load funct3 codes and small extension helpers.
package wb_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef logic [XLEN-1:0]  xlen_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic xlen_t ext8(input logic [7:0] b, input logic sgn);
    return {{(XLEN-8){sgn & b[7]}}, b};
  endfunction

  function automatic xlen_t ext16(input logic [15:0] h, input logic sgn);
    return {{(XLEN-16){sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the byte/half lane of a little-endian
// word, extends it, and flags misaligned or illegal-width accesses.
module wb_load_align
  import wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] raw_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = raw_i[7:0];
    case (addr_i)
      2'd0:    byte_lane = raw_i[7:0];
      2'd1:    byte_lane = raw_i[15:8];
      2'd2:    byte_lane = raw_i[23:16];
      default: byte_lane = raw_i[31:24];
    endcase
    half_lane = addr_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = ext8(byte_lane, 1'b1);
      F3_LBU: data_o = ext8(byte_lane, 1'b0);
      F3_LH: begin
        data_o = ext16(half_lane, 1'b1);
        err_o  = addr_i[0];
      end
      F3_LHU: begin
        data_o = ext16(half_lane, 1'b0);
        err_o  = addr_i[0];
      end
      F3_LW: begin
        data_o = raw_i;
        err_o  = (addr_i != 2'd0);
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: registers the MEM result, selects the writeback
// source, drives the register-file write port and counts retirements.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned      CNT_W       = 64,
  parameter logic [CNT_W-1:0] INSTRET_RST = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_valid_i,
  input  logic              wb_stall_i,
  input  logic              wb_we_i,
  input  logic [1:0]        wb_sel_i,
  input  logic [2:0]        wb_funct3_i,
  input  logic [XLEN-1:0]   wb_alu_i,
  input  logic [XLEN-1:0]   wb_mem_dat_i,
  input  logic [XLEN-1:0]   wb_pc4_i,
  input  logic [REG_W-1:0]  wb_rd_i,
  output logic              wb_rf_we_o,
  output logic [REG_W-1:0]  wb_rf_addr_o,
  output logic [XLEN-1:0]   wb_rf_dat_o,
  output logic              wb_fwd_valid_o,
  output logic              wb_retire_o,
  output logic              wb_exc_o,
  output logic [CNT_W-1:0]  wb_instret_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] load_dat;
  logic            load_err;

  wb_load_align u_load_align (
    .raw_i    (wb_mem_dat_i),
    .addr_i   (wb_alu_i[1:0]),
    .funct3_i (wb_funct3_i),
    .data_o   (load_dat),
    .err_o    (load_err)
  );

  logic              capture;
  logic              is_load;
  logic              exc;
  logic [XLEN-1:0]   result;

  logic              rf_we_d,   rf_we_q;
  logic [REG_W-1:0]  rf_addr_d, rf_addr_q;
  logic [XLEN-1:0]   rf_dat_d,  rf_dat_q;
  logic              retire_d,  retire_q;
  logic              exc_d,     exc_q;
  logic [CNT_W-1:0]  instret_d, instret_q;

  assign capture = wb_valid_i & ~wb_stall_i;
  assign is_load = (wb_sel_e'(wb_sel_i) == WB_SEL_LOAD);
  assign exc     = is_load & load_err;

  always_comb begin
    result = wb_alu_i;
    case (wb_sel_e'(wb_sel_i))
      WB_SEL_LOAD: result = load_dat;
      WB_SEL_PC4:  result = wb_pc4_i;
      default:     result = wb_alu_i;
    endcase
  end

  // Strobes default low every edge; addr/data/count hold unless captured.
  always_comb begin
    rf_we_d   = 1'b0;
    retire_d  = 1'b0;
    exc_d     = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_dat_d  = rf_dat_q;
    instret_d = instret_q;
    if (capture) begin
      rf_addr_d = wb_rd_i;
      if (exc) begin
        exc_d = 1'b1;
      end else begin
        rf_we_d   = wb_we_i & (wb_rd_i != '0);
        retire_d  = 1'b1;
        rf_dat_d  = result;
        instret_d = instret_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_dat_q  <= '0;
      retire_q  <= 1'b0;
      exc_q     <= 1'b0;
      instret_q <= INSTRET_RST;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_dat_q  <= rf_dat_d;
      retire_q  <= retire_d;
      exc_q     <= exc_d;
      instret_q <= instret_d;
    end
  end

  assign wb_rf_we_o     = rf_we_q;
  assign wb_fwd_valid_o = rf_we_q;
  assign wb_rf_addr_o   = rf_addr_q;
  assign wb_rf_dat_o    = rf_dat_q;
  assign wb_retire_o    = retire_q;
  assign wb_exc_o       = exc_q;
  assign wb_instret_o   = instret_q;

endmodule
